// File: rtl/song_sequencer.sv
// song_sequencer: plays a SONG_LEN-step lane pattern, NOTE_TICKS on / GAP_TICKS off per step, one tick = TICK_DIV cycles.
// Define SONG_LOOP_EN to wrap from the last step back to step 0 forever instead of stopping in DONE.
module song_sequencer #(
  parameter int NUM_LANES  = 4,
  parameter int SONG_LEN   = 8,
  parameter logic [SONG_LEN*$clog2(NUM_LANES)-1:0] SONG_PATTERN = 16'hC6E4,
  parameter int TICK_DIV   = 1,
  parameter int NOTE_TICKS = 1,
  parameter int GAP_TICKS  = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     hold,
  output logic [NUM_LANES-1:0]     block,
  output logic                     note_pulse,
  output logic [$clog2(SONG_LEN):0] step_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int STEP_W = $clog2(SONG_LEN) + 1;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_T  = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TCNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [TCNT_W-1:0] NOTE_LAST = TCNT_W'(NOTE_TICKS - 1);
  localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SONG_LEN - 1);

`ifdef SONG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [NUM_LANES-1:0] block_q, block_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tick;
  logic                last_step;
  logic [STEP_W-1:0]   step_nxt;
  logic [LANE_W-1:0]   entry_d;

  function automatic logic [LANE_W-1:0] entry_at(input logic [STEP_W-1:0] s);
    return SONG_PATTERN[int'(s)*LANE_W +: LANE_W];
  endfunction

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    tcnt_d    = tcnt_q;
    step_d    = step_q;
    pulse_d   = 1'b0;
    tick      = (presc_q == PRE_LAST);
    last_step = (step_q == STEP_LAST);
    step_nxt  = last_step ? '0 : step_q + STEP_W'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_NOTE;
          presc_d = '0;
          tcnt_d  = '0;
          step_d  = '0;
          pulse_d = 1'b1;
        end
      end
      S_NOTE: begin
        if (!hold) begin
          presc_d = tick ? '0 : presc_q + PRE_W'(1);
          if (tick) begin
            if (tcnt_q == NOTE_LAST) begin
              tcnt_d = '0;
              if (last_step && !LOOP) begin
                state_d = S_DONE;
              end else if (GAP_TICKS > 0) begin
                state_d = S_GAP;
              end else begin
                // Back-to-back notes: stay in NOTE but restart the note timing.
                step_d  = step_nxt;
                pulse_d = 1'b1;
              end
            end else begin
              tcnt_d = tcnt_q + TCNT_W'(1);
            end
          end
        end
      end
      S_GAP: begin
        if (!hold) begin
          presc_d = tick ? '0 : presc_q + PRE_W'(1);
          if (tick) begin
            if (tcnt_q == GAP_LAST) begin
              tcnt_d  = '0;
              state_d = S_NOTE;
              step_d  = step_nxt;
              pulse_d = 1'b1;
            end else begin
              tcnt_d = tcnt_q + TCNT_W'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered with the state.
    entry_d = entry_at(step_d);
    block_d = '0;
    if (state_d == S_NOTE && int'(entry_d) < NUM_LANES) begin
      block_d = NUM_LANES'(1) << entry_d;
    end
    busy_d = (state_d == S_NOTE) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      step_q  <= '0;
      block_q <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      step_q  <= step_d;
      block_q <= block_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign block      = block_q;
  assign note_pulse = pulse_q;
  assign step_idx   = step_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: basic play, hold, mid-song reset, rest steps, restart and looping.
module tb_song_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start, hold, start_r, hold_r;
  logic [3:0] blk;
  logic       np, busy, done;
  logic [3:0] sidx;
  logic [4:0] blk_r;
  logic       np_r, busy_r, done_r;
  logic [3:0] sidx_r;

  int tests = 0;
  int fails = 0;

  int lanes[8]   = '{0, 1, 2, 3, 2, 1, 0, 3};
  int lanes_r[8] = '{0, 1, 5, 2, 3, 4, 0, 1};

  always #5 Clk = ~Clk;

  song_sequencer #(
    .NUM_LANES(4), .SONG_LEN(8), .SONG_PATTERN(16'hC6E4),
    .TICK_DIV(2), .NOTE_TICKS(2), .GAP_TICKS(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .hold(hold),
    .block(blk), .note_pulse(np), .step_idx(sidx), .busy(busy), .done(done)
  );

  song_sequencer #(
    .NUM_LANES(5), .SONG_LEN(8),
    .SONG_PATTERN({3'd1, 3'd0, 3'd4, 3'd3, 3'd2, 3'd5, 3'd1, 3'd0}),
    .TICK_DIV(2), .NOTE_TICKS(2), .GAP_TICKS(0)
  ) dut_rest (
    .Clk(Clk), .Reset(Reset), .start(start_r), .hold(hold_r),
    .block(blk_r), .note_pulse(np_r), .step_idx(sidx_r), .busy(busy_r), .done(done_r)
  );

  // Reference timing for the main DUT: cycle c counts from the edge that sampled start.
  function automatic int eff(input int c);
`ifdef SONG_LOOP_EN
    if (c < 1) return c;
    return ((c - 1) % 48) + 1;
`else
    return c;
`endif
  endfunction

  function automatic logic [3:0] exp_blk(input int c);
    int e, k, r;
    e = eff(c);
    if (e < 1) return 4'b0000;
    k = (e - 1) / 6;
    r = (e - 1) % 6;
    if (k >= 8 || r >= 4) return 4'b0000;
    return 4'b0001 << lanes[k];
  endfunction

  function automatic logic [3:0] exp_step(input int c);
    int e, k;
    e = eff(c);
    if (e < 1) return 4'd0;
    k = (e - 1) / 6;
    if (k > 7) k = 7;
    return 4'(k);
  endfunction

  function automatic logic exp_pulse(input int c);
    int e;
    e = eff(c);
    if (e < 1) return 1'b0;
    return ((e - 1) % 6 == 0) && ((e - 1) / 6 < 8);
  endfunction

  function automatic logic exp_done(input int c);
`ifdef SONG_LOOP_EN
    return 1'b0;
`else
    return c >= 47;
`endif
  endfunction

  function automatic logic exp_busy(input int c);
    return (c >= 1) && !exp_done(c);
  endfunction

  task automatic tick_cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b1; start = 1'b0; hold = 1'b0; start_r = 1'b0; hold_r = 1'b0;
    tick_cyc();
    tick_cyc();
    Reset = 1'b0;
    tick_cyc();
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b1; hold = 1'b0; start_r = 1'b1; hold_r = 1'b0;
    tick_cyc();
    tick_cyc();
    tests++;
    if ({blk, np, sidx, busy, done} !== 11'b0) begin
      fails++;
      $display("FAIL reset_main got blk=%b np=%b step=%0d busy=%b done=%b want all 0", blk, np, sidx, busy, done);
    end
    tests++;
    if ({blk_r, np_r, sidx_r, busy_r, done_r} !== 12'b0) begin
      fails++;
      $display("FAIL reset_rest got blk=%b np=%b step=%0d busy=%b done=%b want all 0", blk_r, np_r, sidx_r, busy_r, done_r);
    end
    start = 1'b0; start_r = 1'b0;
  endtask

  task automatic test_basic();
    int npulse;
    int ncyc;
    npulse = 0;
`ifdef SONG_LOOP_EN
    ncyc = 100;
`else
    ncyc = 50;
`endif
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick_cyc();
      // Toggling start while looping must not disturb playback.
      start = (c == 60);
      if (np === 1'b1 && c <= 48) npulse++;
      tests++;
      if (blk !== exp_blk(c)) begin
        fails++; $display("FAIL basic_block c=%0d got %b want %b", c, blk, exp_blk(c));
      end
      tests++;
      if (sidx !== exp_step(c)) begin
        fails++; $display("FAIL basic_step c=%0d got %0d want %0d", c, sidx, exp_step(c));
      end
      tests++;
      if (np !== exp_pulse(c)) begin
        fails++; $display("FAIL basic_pulse c=%0d got %b want %b", c, np, exp_pulse(c));
      end
      tests++;
      if (busy !== exp_busy(c) || done !== exp_done(c)) begin
        fails++; $display("FAIL basic_status c=%0d got busy=%b done=%b want busy=%b done=%b",
                          c, busy, done, exp_busy(c), exp_done(c));
      end
    end
    tests++;
    if (npulse != 8) begin
      fails++; $display("FAIL basic_pulse_count got %0d want 8", npulse);
    end
  endtask

  task automatic test_restart();
    // Entered with the main DUT sitting in DONE; start stays high while busy and is ignored.
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick_cyc();
      tests++;
      if (blk !== exp_blk(c) || sidx !== exp_step(c) || np !== exp_pulse(c) || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL restart c=%0d got blk=%b step=%0d np=%b busy=%b done=%b want blk=%b step=%0d np=%b busy=1 done=0",
                 c, blk, sidx, np, busy, done, exp_blk(c), exp_step(c), exp_pulse(c));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_hold();
    int ce;
    logic ep;
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick_cyc();
      start = 1'b0;
      hold  = (c >= 2 && c <= 6);
      ce = (c < 2) ? c : ((c <= 6) ? 1 : c - 5);
      ep = (c >= 2 && c <= 6) ? 1'b0 : exp_pulse(ce);
      tests++;
      if (blk !== exp_blk(ce) || sidx !== exp_step(ce) || np !== ep || busy !== 1'b1) begin
        fails++;
        $display("FAIL hold c=%0d got blk=%b step=%0d np=%b busy=%b want blk=%b step=%0d np=%b busy=1",
                 c, blk, sidx, np, busy, exp_blk(ce), exp_step(ce), ep);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick_cyc();
      start = 1'b0;
    end
    tests++;
    if (blk !== 4'b0010 || sidx !== 4'd1) begin
      fails++; $display("FAIL midreset_pre got blk=%b step=%0d want blk=0010 step=1", blk, sidx);
    end
    Reset = 1'b1;
    tick_cyc();
    Reset = 1'b0;
    tests++;
    if (blk !== 4'b0000 || busy !== 1'b0 || sidx !== 4'd0 || np !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL midreset_post got blk=%b busy=%b step=%0d np=%b done=%b want all 0", blk, busy, sidx, np, done);
    end
    tick_cyc();
    tests++;
    if (busy !== 1'b0 || blk !== 4'b0000) begin
      fails++; $display("FAIL midreset_idle got busy=%b blk=%b want busy=0 blk=0000", busy, blk);
    end
    start = 1'b1;
    hold  = 1'b1;
    tick_cyc();
    start = 1'b0;
    hold  = 1'b0;
    tests++;
    if (blk !== 4'b0001 || sidx !== 4'd0 || np !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL midreset_replay got blk=%b step=%0d np=%b busy=%b want blk=0001 step=0 np=1 busy=1",
                        blk, sidx, np, busy);
    end
  endtask

  task automatic test_rest();
    int k, r;
    logic [4:0] eb;
    apply_reset();
    start_r = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      tick_cyc();
      start_r = 1'b0;
      k = (c - 1) / 4;
      r = (c - 1) % 4;
      eb = (lanes_r[k] < 5) ? (5'b00001 << lanes_r[k]) : 5'b00000;
      tests++;
      if (blk_r !== eb || sidx_r !== 4'(k) || np_r !== (r == 0) || busy_r !== 1'b1) begin
        fails++;
        $display("FAIL rest c=%0d got blk=%b step=%0d np=%b busy=%b want blk=%b step=%0d np=%b busy=1",
                 c, blk_r, sidx_r, np_r, busy_r, eb, k, (r == 0));
      end
    end
`ifndef SONG_LOOP_EN
    tick_cyc();
    tests++;
    if (done_r !== 1'b1 || busy_r !== 1'b0 || blk_r !== 5'b0) begin
      fails++; $display("FAIL rest_done got done=%b busy=%b blk=%b want done=1 busy=0 blk=00000", done_r, busy_r, blk_r);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
`ifndef SONG_LOOP_EN
    test_restart();
`endif
    test_hold();
    test_reset_mid();
    test_rest();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
